// File: rtl/phase_seq_pkg.sv
// Phase sequencer shared definitions.
// FSM state encoding and the phase-count ceiling.
package phase_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_PHASES = 8;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle of the phase sequencer.
// master drives run control, slave is the sequencer side.
interface phase_sequencer_if
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = 4,
    parameter int CYC_W      = 16,
    parameter int SW         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
);
    logic                  enable;
    logic                  mode;
    logic                  step;
    logic                  stall;
    logic [CNT_W-1:0]      len;
    logic [NUM_PHASES-1:0] phase;
    logic [SW-1:0]         state;
    logic                  cycle_start;
    logic                  busy;
    logic [CYC_W-1:0]      cycles;

    modport master (
        output enable, mode, step, stall, len,
        input  phase, state, cycle_start, busy, cycles
    );

    modport slave (
        input  enable, mode, step, stall, len,
        output phase, state, cycle_start, busy, cycles
    );
endinterface

// File: rtl/phase_sequencer_timer.sv
// Per-phase dwell counter with latched length.
// Load restarts at dwell 0, hold freezes, tc marks len-1.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_hold,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] w_len_eff;

    assign w_len_eff = (i_len == '0) ? CNT_W'(1) : i_len;
    assign o_tc      = (r_dwell == r_len - 1'b1);

    // latch length on phase entry, otherwise count unless held
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len   <= CNT_W'(1);
            r_dwell <= '0;
        end else if (i_load) begin
            r_len   <= w_len_eff;
            r_dwell <= '0;
        end else if (!i_hold && !o_tc) begin
            r_dwell <= r_dwell + 1'b1;
        end
    end
endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase machine-cycle sequencer, IDLE/RUN FSM.
// Stall freezes everything; stop only at the last-phase boundary.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = 4,
    parameter int CYC_W      = 16,
    parameter int SW         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  i_CLOCK,
    input  logic                  i_RESET_N,
    input  logic                  i_ENABLE,
    input  logic                  i_MODE,
    input  logic                  i_STEP,
    input  logic                  i_STALL,
    input  logic [CNT_W-1:0]      i_LEN,
    output logic [NUM_PHASES-1:0] o_PHASE,
    output logic [SW-1:0]         o_STATE,
    output logic                  o_CYCLE_START,
    output logic                  o_BUSY,
    output logic [CYC_W-1:0]      o_CYCLES
);
    localparam logic [SW-1:0]         LAST = SW'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] PH0  = NUM_PHASES'(1);

    if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES) begin : g_bad_np
        $error("NUM_PHASES out of range 2..8");
    end

    state_t                r_state;
    logic [NUM_PHASES-1:0] r_phase;
    logic [SW-1:0]         r_idx;
    logic                  r_cstart;
    logic [CYC_W-1:0]      r_cycles;

    logic w_idle;
    logic w_go;
    logic w_tc;
    logic w_last;
    logic w_stop;
    logic w_load;
    logic w_hold;

    assign w_idle = (r_state == IDLE);
    assign w_go   = i_ENABLE & (~i_MODE | i_STEP) & ~i_STALL;
    assign w_last = (r_idx == LAST);
    assign w_stop = i_MODE | ~i_ENABLE;
    assign w_load = (w_idle & w_go) | (~w_idle & ~i_STALL & w_tc);
    assign w_hold = w_idle | i_STALL;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (i_CLOCK),
        .i_rst_n (i_RESET_N),
        .i_load  (w_load),
        .i_hold  (w_hold),
        .i_len   (i_LEN),
        .o_tc    (w_tc)
    );

    // FSM, phase strobe, cycle-start pulse and cycle counter
    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_idx    <= '0;
            r_cstart <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_cstart <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_state  <= RUN;
                        r_idx    <= '0;
                        r_phase  <= PH0;
                        r_cstart <= 1'b1;
                    end
                end
                RUN: begin
                    if (!i_STALL && w_tc) begin
                        if (!w_last) begin
                            r_idx   <= r_idx + 1'b1;
                            r_phase <= r_phase << 1;
                        end else begin
                            r_cycles <= r_cycles + 1'b1;
                            if (w_stop) begin
                                r_state <= IDLE;
                                r_phase <= '0;
                            end else begin
                                r_idx    <= '0;
                                r_phase  <= PH0;
                                r_cstart <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign o_PHASE       = r_phase;
    assign o_STATE       = r_idx;
    assign o_CYCLE_START = r_cstart;
    assign o_BUSY        = (r_state == RUN);
    assign o_CYCLES      = r_cycles;
endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer (3 phases, 4-bit cycles).
// Expected outputs are queued per clock and popped after each edge.
module tb_phase_sequencer;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    logic [10:0] q_exp[$];
    string       q_tag[$];

    phase_sequencer_if #(
        .NUM_PHASES (3),
        .CNT_W      (4),
        .CYC_W      (4)
    ) bus ();

    phase_sequencer #(
        .NUM_PHASES (3),
        .CNT_W      (4),
        .CYC_W      (4)
    ) dut (
        .i_CLOCK       (clk),
        .i_RESET_N     (rst_n),
        .i_ENABLE      (bus.enable),
        .i_MODE        (bus.mode),
        .i_STEP        (bus.step),
        .i_STALL       (bus.stall),
        .i_LEN         (bus.len),
        .o_PHASE       (bus.phase),
        .o_STATE       (bus.state),
        .o_CYCLE_START (bus.cycle_start),
        .o_BUSY        (bus.busy),
        .o_CYCLES      (bus.cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {busy, phase[2:0], state[1:0], cstart, cycles[3:0]}
    function automatic logic [10:0] pk(input logic b, input logic [1:0] st,
                                       input logic cs, input logic [3:0] cy);
        logic [2:0] ph;
        ph = b ? (3'b001 << st) : 3'b000;
        return {b, ph, st, cs, cy};
    endfunction

    task automatic drv(input logic en, input logic md, input logic sp,
                       input logic sl, input logic [3:0] ln,
                       input logic eb, input logic [1:0] es,
                       input logic ec, input logic [3:0] ey,
                       input string tag);
        @(negedge clk);
        bus.enable = en;
        bus.mode   = md;
        bus.step   = sp;
        bus.stall  = sl;
        bus.len    = ln;
        q_exp.push_back(pk(eb, es, ec, ey));
        q_tag.push_back(tag);
    endtask

    // compare DUT outputs just after each rising edge
    always @(posedge clk) begin
        #1;
        if (q_exp.size() > 0) begin
            logic [10:0] e;
            string       t;
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            chk(t, 32'({bus.busy, bus.phase, bus.state,
                        bus.cycle_start, bus.cycles}), 32'(e));
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_phase"}, 32'(bus.phase), 32'd0);
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        chk({tag, "_cs"}, 32'(bus.cycle_start), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_cycles"}, 32'(bus.cycles), 32'd0);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.mode   = 1'b0;
        bus.step   = 1'b0;
        bus.stall  = 1'b0;
        bus.len    = 4'd1;
        repeat (2) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;

        for (int k = 1; k <= 13; k++)
            drv(1, 0, 0, 0, 1, 1, 2'((k - 1) % 3),
                ((k - 1) % 3) == 0, 4'((k - 1) / 3), "free");
        drv(0, 0, 0, 0, 1, 1, 1, 0, 4, "stop1");
        drv(0, 0, 0, 0, 1, 1, 2, 0, 4, "stop2");
        drv(0, 0, 0, 0, 1, 0, 2, 0, 5, "stop_idle");
        drv(0, 0, 0, 0, 1, 0, 2, 0, 5, "stay_idle");

        drv(1, 0, 0, 0, 3, 1, 0, 1, 5, "len_p0a");
        drv(1, 0, 0, 0, 3, 1, 0, 0, 5, "len_p0b");
        drv(1, 0, 0, 0, 3, 1, 0, 0, 5, "len_p0c");
        drv(1, 0, 0, 0, 3, 1, 1, 0, 5, "len_p1a");
        drv(0, 0, 0, 0, 0, 1, 1, 0, 5, "len_p1b");
        drv(0, 0, 0, 0, 0, 1, 1, 0, 5, "len_p1c");
        drv(0, 0, 0, 0, 0, 1, 2, 0, 5, "len_p2");
        drv(0, 0, 0, 0, 0, 0, 2, 0, 6, "len_idle");

        drv(1, 1, 1, 0, 2, 1, 0, 1, 6, "ss_p0a");
        drv(1, 1, 0, 0, 2, 1, 0, 0, 6, "ss_p0b");
        drv(1, 1, 0, 0, 2, 1, 1, 0, 6, "ss_p1a");
        drv(1, 1, 1, 0, 2, 1, 1, 0, 6, "ss_p1b");
        drv(1, 1, 0, 0, 2, 1, 2, 0, 6, "ss_p2a");
        drv(1, 1, 0, 0, 2, 1, 2, 0, 6, "ss_p2b");
        drv(1, 1, 0, 0, 2, 0, 2, 0, 7, "ss_idle");
        drv(1, 1, 0, 0, 2, 0, 2, 0, 7, "ss_stay");

        drv(1, 0, 0, 0, 1, 1, 0, 1, 7, "st_p0");
        drv(1, 0, 0, 0, 1, 1, 1, 0, 7, "st_p1");
        for (int k = 0; k < 5; k++)
            drv(1, 0, 0, 1, 1, 1, 1, 0, 7, "st_hold");
        drv(1, 0, 0, 0, 1, 1, 2, 0, 7, "st_p2");
        drv(1, 0, 0, 1, 1, 1, 2, 0, 7, "st_last");
        drv(0, 0, 0, 0, 1, 0, 2, 0, 8, "st_done");
        drv(1, 0, 0, 1, 1, 0, 2, 0, 8, "st_idle");
        drv(1, 0, 0, 0, 1, 1, 0, 1, 8, "st_go");
        drv(1, 0, 0, 0, 1, 1, 1, 0, 8, "st_mid");

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        @(posedge clk);
        #1;
        chk_zero("arst_hold");
        @(negedge clk);
        bus.enable = 1'b0;
        rst_n      = 1'b1;

        for (int k = 1; k <= 49; k++)
            drv(1, 0, 0, 0, 1, 1, 2'((k - 1) % 3),
                ((k - 1) % 3) == 0, 4'((k - 1) / 3), "wrap");
        drv(0, 0, 0, 0, 1, 1, 1, 0, 0, "wrap_s1");
        drv(0, 0, 0, 0, 1, 1, 2, 0, 0, "wrap_s2");
        drv(0, 0, 0, 0, 1, 0, 2, 0, 1, "wrap_idle");

        for (int i = 0; i < 10 && q_exp.size() > 0; i++)
            @(posedge clk);
        #2;
        chk("drain", 32'(q_exp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
